// File: rtl/apb_mgr_arbiter.sv
// -----------------------------------------------------------------------------
// apb_mgr_arbiter
//
// Shares one APB subordinate bus between two APB managers (m0 = core,
// m1 = debug/DMA). The winning manager's transfer is captured in IDLE and
// replayed on the shared bus as a fresh SETUP/ACCESS sequence. Simultaneous
// requests are resolved round-robin. An ACCESS phase that runs for
// TimeoutCycles cycles is aborted and completed to the manager with PSLVERR.
//
// Ports
//   clk_i, rst_i                      clock, synchronous active-high reset
//   mN_psel_i/penable_i/pwrite_i      manager N APB controls (N = 0, 1)
//   mN_paddr_i, mN_pwdata_i           manager N address / write data
//   mN_prdata_o, mN_pready_o,
//   mN_pslverr_o                      manager N completion
//   s_psel_o/penable_o/pwrite_o,
//   s_paddr_o, s_pwdata_o             shared-bus request
//   s_prdata_i, s_pready_i,
//   s_pslverr_i                       shared-bus completion
//   timeout_o                         one-cycle pulse on each timeout abort
// -----------------------------------------------------------------------------
module apb_mgr_arbiter #(
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,

  input  logic                 m0_psel_i,
  input  logic                 m0_penable_i,
  input  logic                 m0_pwrite_i,
  input  logic [AddrWidth-1:0] m0_paddr_i,
  input  logic [DataWidth-1:0] m0_pwdata_i,
  output logic [DataWidth-1:0] m0_prdata_o,
  output logic                 m0_pready_o,
  output logic                 m0_pslverr_o,

  input  logic                 m1_psel_i,
  input  logic                 m1_penable_i,
  input  logic                 m1_pwrite_i,
  input  logic [AddrWidth-1:0] m1_paddr_i,
  input  logic [DataWidth-1:0] m1_pwdata_i,
  output logic [DataWidth-1:0] m1_prdata_o,
  output logic                 m1_pready_o,
  output logic                 m1_pslverr_o,

  output logic                 s_psel_o,
  output logic                 s_penable_o,
  output logic                 s_pwrite_o,
  output logic [AddrWidth-1:0] s_paddr_o,
  output logic [DataWidth-1:0] s_pwdata_o,
  input  logic [DataWidth-1:0] s_prdata_i,
  input  logic                 s_pready_i,
  input  logic                 s_pslverr_i,

  output logic                 timeout_o
);

  // TimeoutCycles = 0 disables the abort; keep a 1-bit counter so the
  // declarations stay legal in that case.
  localparam bit TimeoutEn   = (TimeoutCycles > 0);
  localparam int CntWidth    = TimeoutEn ? $clog2(TimeoutCycles + 1) : 1;
  localparam int TimeoutLast = TimeoutEn ? TimeoutCycles - 1 : 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic                  grant_reg, grant_next;
  logic                  last_reg,  last_next;
  logic [AddrWidth-1:0]  addr_reg,  addr_next;
  logic [DataWidth-1:0]  wdata_reg, wdata_next;
  logic                  write_reg, write_next;
  logic [CntWidth-1:0]   cnt_reg,   cnt_next;

  logic                  winner;
  logic                  complete;
  logic                  abort;
  logic                  timeout_hit;

  // PENABLE from the managers carries no information for the arbiter: a
  // request is recognised on PSEL alone.
  logic unused_penable;
  assign unused_penable = &{1'b0, m0_penable_i, m1_penable_i};

  assign timeout_hit = TimeoutEn && (cnt_reg == CntWidth'(TimeoutLast));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      grant_reg <= 1'b0;
      last_reg  <= 1'b1;   // m0 wins the first tie after reset
      addr_reg  <= '0;
      wdata_reg <= '0;
      write_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      last_reg  <= last_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      write_reg <= write_next;
      cnt_reg   <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    last_next  = last_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    write_next = write_reg;
    cnt_next   = '0;       // counter only survives while in ACCESS
    winner     = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (m0_psel_i || m1_psel_i) begin
          // On a tie the manager that did not win last time goes next.
          if (m0_psel_i && m1_psel_i) begin
            winner = ~last_reg;
          end else begin
            winner = m1_psel_i;
          end
          grant_next = winner;
          last_next  = winner;
          addr_next  = winner ? m1_paddr_i  : m0_paddr_i;
          wdata_next = winner ? m1_pwdata_i : m0_pwdata_i;
          write_next = winner ? m1_pwrite_i : m0_pwrite_i;
          state_next = SETUP;
        end
      end

      SETUP: begin
        state_next = ACCESS;
      end

      ACCESS: begin
        // A late PREADY on the timeout cycle still wins over the abort.
        if (s_pready_i) begin
          complete   = 1'b1;
          state_next = IDLE;
        end else if (timeout_hit) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (TimeoutEn) begin
          cnt_next = cnt_reg + CntWidth'(1);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shared-bus outputs: driven only while a transfer is in flight
  // ---------------------------------------------------------------------------
  assign s_psel_o    = (state_reg == SETUP) || (state_reg == ACCESS);
  assign s_penable_o = (state_reg == ACCESS);
  assign s_pwrite_o  = s_psel_o & write_reg;
  assign s_paddr_o   = s_psel_o ? addr_reg  : '0;
  assign s_pwdata_o  = s_psel_o ? wdata_reg : '0;
  assign timeout_o   = abort;

  // ---------------------------------------------------------------------------
  // Manager-side returns: only the granted manager ever sees a completion,
  // which keeps the other one parked in its own ACCESS phase.
  // ---------------------------------------------------------------------------
  logic [1:0]           mgr_pready;
  logic [1:0]           mgr_pslverr;
  logic [DataWidth-1:0] mgr_prdata [2];

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_mgr
    logic sel;
    assign sel              = (grant_reg == 1'(gi));
    assign mgr_pready[gi]   = sel & (complete | abort);
    assign mgr_pslverr[gi]  = sel & (abort | (complete & s_pslverr_i));
    assign mgr_prdata[gi]   = (sel & complete) ? s_prdata_i : '0;
  end

  assign m0_pready_o  = mgr_pready[0];
  assign m0_pslverr_o = mgr_pslverr[0];
  assign m0_prdata_o  = mgr_prdata[0];
  assign m1_pready_o  = mgr_pready[1];
  assign m1_pslverr_o = mgr_pslverr[1];
  assign m1_prdata_o  = mgr_prdata[1];

endmodule

// File: tb/tb_apb_mgr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apb_mgr_arbiter
//
// Directed bench for apb_mgr_arbiter (TimeoutCycles = 8). Two small manager
// drivers and a subordinate responder generate traffic; a transfer-level
// model predicts every output on every cycle from the arbitration rules, and
// each test adds literal expectations for the cycles the scenarios call out.
// -----------------------------------------------------------------------------
module tb_apb_mgr_arbiter;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // manager-side stimulus
  logic        m_psel   [2] = '{default: 1'b0};
  logic        m_pen    [2] = '{default: 1'b0};
  logic        m_pwrite [2] = '{default: 1'b0};
  logic [31:0] m_paddr  [2] = '{default: 32'h0};
  logic [31:0] m_pwdata [2] = '{default: 32'h0};

  logic [31:0] m0_prdata, m1_prdata;
  logic        m0_pready, m0_pslverr, m1_pready, m1_pslverr;

  logic        s_psel, s_pen, s_pwrite;
  logic [31:0] s_paddr, s_pwdata;
  logic [31:0] s_prdata  = 32'hBAD0_BAD0;
  logic        s_pready  = 1'b0;
  logic        s_pslverr = 1'b0;
  logic        timeout;

  apb_mgr_arbiter #(
    .AddrWidth     (32),
    .DataWidth     (32),
    .TimeoutCycles (TO)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .m0_psel_i    (m_psel[0]),
    .m0_penable_i (m_pen[0]),
    .m0_pwrite_i  (m_pwrite[0]),
    .m0_paddr_i   (m_paddr[0]),
    .m0_pwdata_i  (m_pwdata[0]),
    .m0_prdata_o  (m0_prdata),
    .m0_pready_o  (m0_pready),
    .m0_pslverr_o (m0_pslverr),
    .m1_psel_i    (m_psel[1]),
    .m1_penable_i (m_pen[1]),
    .m1_pwrite_i  (m_pwrite[1]),
    .m1_paddr_i   (m_paddr[1]),
    .m1_pwdata_i  (m_pwdata[1]),
    .m1_prdata_o  (m1_prdata),
    .m1_pready_o  (m1_pready),
    .m1_pslverr_o (m1_pslverr),
    .s_psel_o     (s_psel),
    .s_penable_o  (s_pen),
    .s_pwrite_o   (s_pwrite),
    .s_paddr_o    (s_paddr),
    .s_pwdata_o   (s_pwdata),
    .s_prdata_i   (s_prdata),
    .s_pready_i   (s_pready),
    .s_pslverr_i  (s_pslverr),
    .timeout_o    (timeout)
  );

  int checks = 0;
  int errors = 0;

  function automatic void check(input string name, input logic [95:0] act,
                                input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Manager drivers: each runs `pend` transfers; a new SETUP is presented in
  // the cycle right after a completion (PSEL held, PENABLE low).
  // ---------------------------------------------------------------------------
  bit          active    [2] = '{default: 1'b0};
  int          pend      [2] = '{default: 0};
  int          issued    [2] = '{default: 0};
  bit          mwr       [2] = '{default: 1'b0};
  logic [31:0] abase     [2] = '{default: 32'h0};
  logic [31:0] dbase     [2] = '{default: 32'h0};
  bit          done_seen [2] = '{default: 1'b0};

  always @(negedge clk) begin
    done_seen[0] = m0_pready;
    done_seen[1] = m1_pready;
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        active[i] = 1'b0;
        pend[i]   = 0;
        m_psel[i] = 1'b0;
        m_pen[i]  = 1'b0;
      end else if (active[i] && done_seen[i]) begin
        active[i] = 1'b0;
        pend[i]   = pend[i] - 1;
        issued[i] = issued[i] + 1;
        m_pen[i]  = 1'b0;
        m_psel[i] = 1'b0;
        if (pend[i] > 0) begin
          active[i]   = 1'b1;
          m_psel[i]   = 1'b1;
          m_pwrite[i] = mwr[i];
          m_paddr[i]  = abase[i] + 32'(issued[i] * 4);
          m_pwdata[i] = dbase[i] + 32'(issued[i]);
        end
      end else if (active[i]) begin
        m_pen[i] = 1'b1;
      end else if (pend[i] > 0) begin
        active[i]   = 1'b1;
        m_psel[i]   = 1'b1;
        m_pen[i]    = 1'b0;
        m_pwrite[i] = mwr[i];
        m_paddr[i]  = abase[i] + 32'(issued[i] * 4);
        m_pwdata[i] = dbase[i] + 32'(issued[i]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Subordinate responder: `sub_wait` not-ready ACCESS cycles, then ready;
  // `sub_hang` never ready. Garbage on PRDATA/PSLVERR while not ready.
  // ---------------------------------------------------------------------------
  int          sub_wait = 0;
  bit          sub_hang = 1'b0;
  bit          sub_err  = 1'b0;
  int          acc      = 0;
  logic [31:0] rd_q[$];

  always @(posedge clk) begin
    #1;
    if (s_psel && s_pen) begin
      acc = acc + 1;
      if (!sub_hang && acc > sub_wait) begin
        s_pready  = 1'b1;
        s_pslverr = sub_err;
        if (rd_q.size() > 0) s_prdata = rd_q.pop_front();
        else                 s_prdata = s_paddr ^ 32'h00FF_00FF;
      end else begin
        s_pready  = 1'b0;
        s_pslverr = sub_err;
        s_prdata  = 32'hBAD0_BAD0;
      end
    end else begin
      acc       = 0;
      s_pready  = 1'b0;
      s_pslverr = 1'b0;
      s_prdata  = 32'hBAD0_BAD0;
    end
  end

  // ---------------------------------------------------------------------------
  // Transfer-level model. A transfer granted in cycle S shows SETUP in S+1 and
  // ACCESS from S+2; the n-th ACCESS cycle completes on PREADY, or aborts when
  // n reaches TO. The bus is free again the cycle after completion.
  // ---------------------------------------------------------------------------
  int          cyc      = 0;
  bit          model_on = 1'b0;
  bit          m_busy   = 1'b0;
  bit          m_owner  = 1'b0;
  bit          m_last   = 1'b1;
  bit          m_write  = 1'b0;
  int          m_start  = 0;
  logic [31:0] m_addr   = 32'h0;
  logic [31:0] m_wdata  = 32'h0;
  int          g_n      = 0;
  int          log_who   [128];
  int          log_start [128];
  int          log_done  [128];

  always @(negedge clk) begin
    logic [66:0] exp_s;
    logic [33:0] exp_m0, exp_m1;
    logic        exp_to;
    bit          done;
    int          phase;
    exp_s  = '0;
    exp_m0 = '0;
    exp_m1 = '0;
    exp_to = 1'b0;
    done   = 1'b0;
    phase  = 0;
    if (model_on) begin
      if (m_busy) begin
        phase = cyc - m_start;
        exp_s = {1'b1, (phase >= 2), m_write, m_addr, m_wdata};
        if (phase >= 2) begin
          if (s_pready === 1'b1) begin
            if (m_owner) exp_m1 = {1'b1, s_pslverr, s_prdata};
            else         exp_m0 = {1'b1, s_pslverr, s_prdata};
            done = 1'b1;
          end else if (phase - 1 == TO) begin
            if (m_owner) exp_m1 = {2'b11, 32'h0};
            else         exp_m0 = {2'b11, 32'h0};
            exp_to = 1'b1;
            done   = 1'b1;
          end
        end
      end
      check($sformatf("cyc%0d_sbus", cyc), {s_psel, s_pen, s_pwrite, s_paddr, s_pwdata}, exp_s);
      check($sformatf("cyc%0d_m0", cyc), {m0_pready, m0_pslverr, m0_prdata}, exp_m0);
      check($sformatf("cyc%0d_m1", cyc), {m1_pready, m1_pslverr, m1_prdata}, exp_m1);
      check($sformatf("cyc%0d_timeout", cyc), timeout, exp_to);
      if (done) begin
        log_done[g_n-1] = cyc;
        $display("xfer %0d: mgr%0d %s addr=%h wdata=%h rdata=%h err=%0d timeout=%0d cycles=%0d",
                 g_n - 1, m_owner, m_write ? "WR" : "RD", m_addr, m_wdata,
                 m_owner ? exp_m1[31:0] : exp_m0[31:0],
                 m_owner ? exp_m1[32] : exp_m0[32], exp_to, phase + 1);
        m_busy = 1'b0;
      end else if (!m_busy && (m_psel[0] || m_psel[1])) begin
        m_owner = (m_psel[0] && m_psel[1]) ? !m_last : m_psel[1];
        m_last  = m_owner;
        m_addr  = m_paddr[m_owner];
        m_wdata = m_pwdata[m_owner];
        m_write = m_pwrite[m_owner];
        m_busy  = 1'b1;
        m_start = cyc;
        log_who[g_n]   = m_owner;
        log_start[g_n] = cyc;
        g_n = g_n + 1;
      end
    end
    if (rst) begin
      model_on = 1'b1;
      m_busy   = 1'b0;
      m_last   = 1'b1;
    end
    cyc = cyc + 1;
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic negs(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start(input int i, input int n, input bit w,
                       input logic [31:0] a, input logic [31:0] d);
    mwr[i]    = w;
    abase[i]  = a;
    dbase[i]  = d;
    issued[i] = 0;
    pend[i]   = n;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while ((pend[0] != 0 || pend[1] != 0 || active[0] || active[1]) && k < 200) begin
      @(posedge clk);
      k++;
    end
    check({tag, "_drained"}, 96'(k < 200), 96'(1));
    tick();
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  bit exp_order [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  initial begin
    int g0, cnt_rdy, cnt_to;

    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    // Reset state: everything quiet.
    negs(1);
    check("reset_outputs",
          {s_psel, s_pen, s_pwrite, s_paddr, timeout, m0_pready, m1_pready},
          '0);
    tick();

    // 1: m0 write, zero-wait subordinate -> 3-cycle transfer.
    start(0, 1, 1'b1, 32'h0300_0004, 32'hDEAD_BEEF);
    negs(2);
    check("t1_idle_psel", s_psel, 0);
    negs(1);
    check("t1_setup", {s_psel, s_pen, s_pwrite, s_paddr, s_pwdata},
          {3'b101, 32'h0300_0004, 32'hDEAD_BEEF});
    negs(1);
    check("t1_access", {s_psel, s_pen, s_paddr, s_pwdata},
          {2'b11, 32'h0300_0004, 32'hDEAD_BEEF});
    check("t1_m0_pready", m0_pready, 1);
    check("t1_m1_quiet", {m1_pready, m1_pslverr, m1_prdata}, 0);
    wait_idle("t1");

    // 2: simultaneous reads after reset -> m0 (0x11) then m1 (0x22).
    do_reset();
    rd_q.push_back(32'h11);
    rd_q.push_back(32'h22);
    start(0, 1, 1'b0, 32'h0000_0100, 32'h0);
    start(1, 1, 1'b0, 32'h0000_0200, 32'h0);
    negs(4);
    check("t2_m0_done", {m0_pready, m0_prdata}, {1'b1, 32'h11});
    check("t2_m1_held", m1_pready, 0);
    negs(3);
    check("t2_m1_done", {m1_pready, m1_prdata}, {1'b1, 32'h22});
    check("t2_m0_quiet", m0_pready, 0);
    wait_idle("t2a");
    // After a solo m0 transfer the next tie belongs to m1.
    start(0, 1, 1'b0, 32'h0000_0104, 32'h0);
    wait_idle("t2b");
    g0 = g_n;
    rd_q.push_back(32'h44);
    rd_q.push_back(32'h55);
    start(0, 1, 1'b0, 32'h0000_0108, 32'h0);
    start(1, 1, 1'b0, 32'h0000_0204, 32'h0);
    wait_idle("t2c");
    check("t2_tie2_first", log_who[g0], 1);
    check("t2_tie2_second", log_who[g0+1], 0);

    // 3: m1 read, 5 wait states then PSLVERR.
    sub_wait = 5;
    sub_err  = 1'b1;
    start(1, 1, 1'b0, 32'h0000_0300, 32'h0);
    negs(2);
    cnt_rdy = 0;
    cnt_to  = 0;
    for (int k = 1; k <= 8; k++) begin
      negs(1);
      cnt_rdy += int'(m1_pready);
      cnt_to  += int'(timeout);
      if (k == 7) check("t3_final", {m1_pready, m1_pslverr}, 2'b11);
    end
    check("t3_pready_count", cnt_rdy, 1);
    check("t3_no_timeout", cnt_to, 0);
    wait_idle("t3");
    sub_wait = 0;
    sub_err  = 1'b0;

    // 4: m0 read, subordinate hangs -> abort on the 8th ACCESS cycle.
    sub_hang = 1'b1;
    start(0, 1, 1'b0, 32'h0000_0400, 32'h0);
    negs(2);
    cnt_to = 0;
    for (int k = 1; k <= 9; k++) begin
      negs(1);
      cnt_to += int'(timeout);
      if (k == 8) check("t4_not_early", m0_pready, 0);
      if (k == 9) check("t4_abort", {m0_pready, m0_pslverr, m0_prdata, timeout},
                        {2'b11, 32'h0, 1'b1});
    end
    negs(1);
    check("t4_bus_released", {s_psel, timeout}, 0);
    check("t4_one_pulse", cnt_to, 1);
    wait_idle("t4");
    sub_hang = 1'b0;

    // 5: reset during ACCESS of an m1 write.
    sub_hang = 1'b1;
    start(1, 1, 1'b1, 32'h0000_0500, 32'hCAFE_F00D);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    negs(1);
    check("t5_in_access", {s_psel, s_pen}, 2'b11);
    tick();
    rst = 1'b0;
    negs(1);
    check("t5_after_reset",
          {s_psel, s_pen, s_pwrite, s_paddr, s_pwdata, timeout,
           m1_pready, m1_pslverr, m0_pready},
          '0);
    tick();
    sub_hang = 1'b0;
    start(0, 1, 1'b0, 32'h0000_0600, 32'h0);
    start(1, 1, 1'b0, 32'h0000_0604, 32'h0);
    negs(3);
    check("t5_m0_wins", {s_psel, s_paddr}, {1'b1, 32'h0000_0600});
    wait_idle("t5");

    // 6: 4 back-to-back m0 writes against a continuously requesting m1.
    start(0, 1, 1'b0, 32'h0000_0700, 32'h0);
    wait_idle("t6a");
    g0 = g_n;
    start(0, 4, 1'b1, 32'h0000_0800, 32'h0000_1000);
    start(1, 4, 1'b0, 32'h0000_0900, 32'h0);
    wait_idle("t6b");
    check("t6_count", g_n - g0, 8);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t6_grant%0d", k), log_who[g0+k], exp_order[k]);
    end
    for (int k = 1; k < 8; k++) begin
      check($sformatf("t6_gap%0d", k), log_start[g0+k] - log_done[g0+k-1], 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
